// File: rtl/ln_core_arbiter.sv
// ln_core_arbiter
//   Shares one layer_norm_top core between two column requesters. One column
//   is accepted per grant with round-robin fairness, the core start/done
//   handshake is sequenced, and the normalised column is returned to the
//   granted requester. A watchdog aborts an operation whose core never answers.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req0_valid/x/ready       requester 0 column handshake
//   req1_valid/x/ready       requester 1 column handshake
//   resp_done0, resp_done1   1-cycle response pulse for the granted requester
//   resp_err                 1 = watchdog abort (resp_y forced to 0)
//   resp_y                   registered result, held until the next response
//   busy                     1 whenever the arbiter is not idle
//   grant_id                 requester owning the current or last operation
//   ln_start_in, ln_x_in     start pulse and operand register towards the core
//   ln_done_out, ln_y_out    completion pulse and result from the core
//
// state   | meaning
// S_IDLE  | waiting for a request, ready offered to the round-robin winner
// S_START | operand registered, start pulse driven to the core
// S_WAIT  | waiting for core done, watchdog counting
// S_RESP  | result registered, done pulse to the granted requester
module ln_core_arbiter #(
  parameter int D_MODEL        = 64,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0_valid,
  input  logic [D_MODEL*DATA_WIDTH-1:0] req0_x,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [D_MODEL*DATA_WIDTH-1:0] req1_x,
  output logic                          req1_ready,
  output logic                          resp_done0,
  output logic                          resp_done1,
  output logic                          resp_err,
  output logic [D_MODEL*DATA_WIDTH-1:0] resp_y,
  output logic                          busy,
  output logic                          grant_id,
  output logic                          ln_start_in,
  output logic [D_MODEL*DATA_WIDTH-1:0] ln_x_in,
  input  logic                          ln_done_out,
  input  logic [D_MODEL*DATA_WIDTH-1:0] ln_y_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic        last_grant;
  logic [15:0] wd_cnt;
  logic        any_valid;
  logic        pick;
  logic        wd_expire;

  // Winner selection: a lone requester always wins; under contention the
  // requester that did not own the previous operation wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid)
      pick = ~last_grant;
    else
      pick = req1_valid;
  end

  assign req0_ready  = (state == S_IDLE) && any_valid && !pick;
  assign req1_ready  = (state == S_IDLE) && any_valid && pick;
  assign ln_start_in = (state == S_START);
  assign busy        = (state != S_IDLE);
  assign resp_done0  = (state == S_RESP) && !grant_id;
  assign resp_done1  = (state == S_RESP) && grant_id;
  assign wd_expire   = WD_EN && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      ln_x_in    <= '0;
      resp_y     <= '0;
      resp_err   <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            ln_x_in    <= pick ? req1_x : req0_x;
            grant_id   <= pick;
            last_grant <= pick;
            resp_err   <= 1'b0;
            state      <= S_START;
          end
        end
        S_START: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // A done coinciding with expiry takes priority: the result is good.
          if (ln_done_out) begin
            resp_y   <= ln_y_out;
            resp_err <= 1'b0;
            state    <= S_RESP;
          end else if (wd_expire) begin
            resp_y   <= '0;
            resp_err <= 1'b1;
            state    <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ln_core_arbiter.sv
// tb_ln_core_arbiter
//   Drives two requesters and a core model around ln_core_arbiter. A
//   transaction-level reference model predicts every output each cycle from
//   the time elapsed since the accepting edge; directed scenarios add literal
//   expectations on latency, grant order, watchdog timing and reset.
module tb_ln_core_arbiter;

  localparam int D  = 64;
  localparam int DW = 16;
  localparam int TO = 8;
  localparam int W  = D * DW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_x = '0, req1_x = '0;
  logic         req0_ready, req1_ready;
  logic         resp_done0, resp_done1, resp_err, busy, grant_id, ln_start_in;
  logic [W-1:0] resp_y, ln_x_in;
  logic         ln_done_out = 1'b0;
  logic [W-1:0] ln_y_out = '0;

  always #5 clk = ~clk;

  ln_core_arbiter #(.D_MODEL(D), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_ready(req1_ready),
    .resp_done0(resp_done0), .resp_done1(resp_done1), .resp_err(resp_err),
    .resp_y(resp_y), .busy(busy), .grant_id(grant_id),
    .ln_start_in(ln_start_in), .ln_x_in(ln_x_in),
    .ln_done_out(ln_done_out), .ln_y_out(ln_y_out)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: one operation record plus the registered results
  bit           m_active = 0, m_last = 1, m_grant = 0, m_err = 0;
  logic [W-1:0] m_x = '0, m_y = '0;
  int           m_t = 0, m_resp_at = -1;

  // observed events for the directed checks
  int ev_xfer_c = 0, ev_start_c = 0, ev_donein_c = 0, ev_resp_c = 0, n_resp = 0;
  bit ev_resp_id = 0;
  bit gq[$];

  // stimulus knobs
  int           cd = 0, lat_fixed = 5, stray_pct = 0, rate = 0;
  bit           lat_rand = 0, y_fixed = 1, auto0 = 0, auto1 = 0;
  logic [W-1:0] y_val = '0;

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [W-1:0] rep16(logic [15:0] e);
    logic [W-1:0] v;
    for (int i = 0; i < D; i++) v[i*DW +: DW] = e;
    return v;
  endfunction

  task automatic chk1(string nm, logic a, logic e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cyc=%0d act=%0b exp=%0b", nm, cyc, a, e);
    end
  endtask

  task automatic chki(string nm, int a, int e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s cyc=%0d act=%0d exp=%0d", nm, cyc, a, e);
    end
  endtask

  task automatic chkw(string nm, logic [W-1:0] a, logic [W-1:0] e);
    n_tests++;
    if (a !== e) begin
      int k = 0;
      for (int i = D - 1; i >= 0; i--) if (a[i*DW +: DW] !== e[i*DW +: DW]) k = i;
      n_fail++;
      $display("FAIL %s cyc=%0d elem%0d act=%h exp=%h", nm, cyc, k,
               a[k*DW +: DW], e[k*DW +: DW]);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  // with this cycle's inputs (they take effect at the coming edge).
  task automatic model_step();
    bit win, e_r0, e_r1, e_st, e_d0, e_d1;
    cyc++;
    if (rst) begin
      m_active = 0; m_last = 1; m_grant = 0; m_err = 0;
      m_x = '0; m_y = '0; m_resp_at = -1;
      chk1("rst_ready0", req0_ready, 1'b0);
      chk1("rst_ready1", req1_ready, 1'b0);
      chk1("rst_done0", resp_done0, 1'b0);
      chk1("rst_done1", resp_done1, 1'b0);
      chk1("rst_err", resp_err, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_grant", grant_id, 1'b0);
      chk1("rst_start", ln_start_in, 1'b0);
      chkw("rst_x", ln_x_in, '0);
      chkw("rst_y", resp_y, '0);
      return;
    end
    win  = (req0_valid && req1_valid) ? !m_last : req1_valid;
    e_r0 = !m_active && (req0_valid || req1_valid) && !win;
    e_r1 = !m_active && (req0_valid || req1_valid) && win;
    e_st = m_active && (cyc == m_t + 1);
    e_d0 = m_active && (cyc == m_resp_at) && !m_grant;
    e_d1 = m_active && (cyc == m_resp_at) && m_grant;
    chk1("ready0", req0_ready, e_r0);
    chk1("ready1", req1_ready, e_r1);
    chk1("start", ln_start_in, e_st);
    chk1("done0", resp_done0, e_d0);
    chk1("done1", resp_done1, e_d1);
    chk1("busy", busy, m_active);
    chk1("grant_id", grant_id, m_grant);
    chk1("resp_err", resp_err, m_err);
    chkw("ln_x_in", ln_x_in, m_x);
    chkw("resp_y", resp_y, m_y);

    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
      ev_xfer_c = cyc;
      gq.push_back(req1_ready);
    end
    if (ln_start_in) ev_start_c = cyc;
    if (ln_done_out) ev_donein_c = cyc;
    if (resp_done0 || resp_done1) begin
      ev_resp_c = cyc; ev_resp_id = resp_done1; n_resp++;
    end

    if (!m_active) begin
      if (req0_valid || req1_valid) begin
        m_active = 1; m_t = cyc; m_grant = win; m_last = win;
        m_x = win ? req1_x : req0_x; m_err = 0; m_resp_at = -1;
      end
    end else if (m_resp_at < 0) begin
      if (cyc >= m_t + 2) begin
        if (ln_done_out) begin
          m_resp_at = cyc + 1; m_y = ln_y_out; m_err = 0;
        end else if (TO != 0 && (cyc - (m_t + 2)) == TO - 1) begin
          m_resp_at = cyc + 1; m_y = '0; m_err = 1;
        end
      end
    end else if (cyc == m_resp_at) begin
      m_active = 0;
    end
  endtask

  // One clock: check at the falling edge, drive inputs 1 time unit after
  // the rising edge.
  task automatic tick();
    bit acc0, acc1, st;
    @(negedge clk);
    model_step();
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    st   = ln_start_in;
    @(posedge clk);
    #1;
    if (st) begin
      if (lat_rand) cd = ($urandom_range(0, 9) < 2) ? 0 : int'($urandom_range(1, 11));
      else          cd = lat_fixed;
    end
    ln_done_out = 1'b0;
    ln_y_out    = rnd_vec();
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        ln_done_out = 1'b1;
        ln_y_out    = y_fixed ? y_val : rnd_vec();
      end
    end
    if (!ln_done_out && $urandom_range(0, 99) < stray_pct) ln_done_out = 1'b1;
    if (acc0) req0_valid = 1'b0;
    if (acc1) req1_valid = 1'b0;
    if (auto0 && !req0_valid && $urandom_range(0, 99) < rate) begin
      req0_valid = 1'b1; req0_x = rnd_vec();
    end
    if (auto1 && !req1_valid && $urandom_range(0, 99) < rate) begin
      req1_valid = 1'b1; req1_x = rnd_vec();
    end
  endtask

  task automatic wait_resp(string nm, int budget);
    int base = n_resp;
    int k = 0;
    while (n_resp == base && k < budget) begin
      tick();
      k++;
    end
    chk1(nm, n_resp != base, 1'b1);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] p1;
    int base;

    do_reset(3);

    // single operation, 5-cycle core
    y_val = rep16(16'h0200); lat_fixed = 5;
    req0_valid = 1'b1; req0_x = rep16(16'h0100);
    wait_resp("t1_wait", 40);
    chki("t1_start_lat", ev_start_c - ev_xfer_c, 1);
    chki("t1_core_lat", ev_donein_c - ev_start_c, 5);
    chki("t1_resp_lat", ev_resp_c - ev_donein_c, 1);
    chk1("t1_resp_id", ev_resp_id, 1'b0);
    chkw("t1_resp_y", resp_y, rep16(16'h0200));
    chk1("t1_resp_err", resp_err, 1'b0);

    // contention from reset: grants alternate starting with requester 0
    do_reset(2);
    gq.delete();
    y_fixed = 0; lat_fixed = 3; rate = 100; auto0 = 1; auto1 = 1;
    req0_valid = 1'b1; req0_x = rnd_vec();
    req1_valid = 1'b1; req1_x = rnd_vec();
    for (int i = 0; i < 4; i++) begin
      wait_resp("t2_wait", 40);
      chk1("t2_resp_id", ev_resp_id, i[0]);
    end
    auto0 = 0; auto1 = 0; req0_valid = 1'b0; req1_valid = 1'b0;
    chk1("t2_count", gq.size() >= 4, 1'b1);
    if (gq.size() >= 4)
      for (int i = 0; i < 4; i++) chk1("t2_order", gq[i], i[0]);
    repeat (3) tick();

    // back-pressure: requester 1 arrives while requester 0 is in flight
    lat_fixed = 5; p1 = rnd_vec();
    req0_valid = 1'b1; req0_x = rnd_vec();
    tick(); tick();
    req1_valid = 1'b1; req1_x = p1;
    wait_resp("t3_wait0", 40);
    tick();
    chki("t3_first_idle", ev_xfer_c, ev_resp_c + 1);
    chk1("t3_grant1", gq[$], 1'b1);
    tick();
    chkw("t3_x_captured", ln_x_in, p1);
    wait_resp("t3_wait1", 40);
    tick();

    // watchdog: core never answers
    lat_fixed = 0;
    req0_valid = 1'b1; req0_x = rnd_vec();
    wait_resp("t4_wait", 40);
    chki("t4_wd_time", ev_resp_c - (ev_start_c + 1), TO);
    chk1("t4_err", resp_err, 1'b1);
    chkw("t4_y_zero", resp_y, '0);
    chk1("t4_resp_id", ev_resp_id, 1'b0);
    tick();
    // done in the very cycle the watchdog would expire is a good result
    y_fixed = 1; y_val = rep16(16'h0808); lat_fixed = TO;
    req0_valid = 1'b1; req0_x = rnd_vec();
    wait_resp("t4_edge_wait", 40);
    chk1("t4_edge_err", resp_err, 1'b0);
    chkw("t4_edge_y", resp_y, rep16(16'h0808));
    tick();
    y_val = rep16(16'h0A5A); lat_fixed = 3;
    req0_valid = 1'b1; req0_x = rnd_vec();
    wait_resp("t4_next_wait", 40);
    chk1("t4_next_err", resp_err, 1'b0);
    chkw("t4_next_y", resp_y, rep16(16'h0A5A));
    tick();

    // stray done while idle, then during the start cycle
    base = n_resp;
    stray_pct = 100;
    repeat (3) tick();
    stray_pct = 0;
    chki("t5_idle_no_resp", n_resp, base);
    chkw("t5_idle_y_kept", resp_y, rep16(16'h0A5A));
    y_val = rep16(16'h3C3C); lat_fixed = 4;
    req0_valid = 1'b1; req0_x = rnd_vec();
    tick();
    ln_done_out = 1'b1; ln_y_out = rnd_vec();
    wait_resp("t5_wait", 40);
    chki("t5_one_resp", n_resp, base + 1);
    chkw("t5_y", resp_y, rep16(16'h3C3C));
    tick();

    // reset while waiting on the core; its late done must be ignored
    y_val = rep16(16'h1111); lat_fixed = 6;
    req0_valid = 1'b1; req0_x = rnd_vec();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk1("t6_busy", busy, 1'b0);
    chkw("t6_y", resp_y, '0);
    chkw("t6_x", ln_x_in, '0);
    tick();
    rst = 1'b0;
    base = n_resp;
    repeat (8) tick();
    chki("t6_no_resp", n_resp, base);
    y_val = rep16(16'h2222); lat_fixed = 2;
    req0_valid = 1'b1; req0_x = rnd_vec();
    wait_resp("t6_next_wait", 40);
    chk1("t6_next_id", ev_resp_id, 1'b0);
    chk1("t6_next_err", resp_err, 1'b0);
    chkw("t6_next_y", resp_y, rep16(16'h2222));

    // randomized traffic, latencies, hangs and stray dones
    y_fixed = 0; lat_rand = 1; stray_pct = 5; rate = 30; auto0 = 1; auto1 = 1;
    repeat (3000) tick();
    auto0 = 0; auto1 = 0; stray_pct = 0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
